reg_bank_mp: RTL and testbench

Parametrised multi-port register bank with hardwired-zero register 0, same-cycle write-to-read bypass, per-register pending-write scoreboard and deterministic write-port priority. It is the next generation of the single-write, single-bypass-port bank. It sits between decode (read/issue) and writeback (write) in the Fibonacci microprocessor datapath. It provides operand values plus an operand-ready flag per read port so the issue stage can stall on hazards.

---
 rtl/reg_bank_mp_if.sv | 28 ++
 rtl/reg_bank_mp.sv | 89 ++++++++
 tb/tb_reg_bank_mp.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_mp_if.sv
// Bus bundle for the multi-port register bank: write ports, read ports,
// issue/scoreboard signals. Ports are packed flat, port n at [n*W +: W].
interface reg_bank_mp_if #(
    parameter int DIR_WIDTH  = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 2
);
    logic [NUM_WRITE-1:0]             write_en;
    logic [NUM_WRITE*DIR_WIDTH-1:0]   write_dir;
    logic [NUM_WRITE*DATA_WIDTH-1:0]  write_data;
    logic [NUM_READ*DIR_WIDTH-1:0]    read_dir;
    logic [NUM_READ*DATA_WIDTH-1:0]   read_data;
    logic [NUM_READ-1:0]              read_ready;
    logic                             issue_en;
    logic [DIR_WIDTH-1:0]             issue_dir;
    logic [(1<<DIR_WIDTH)-1:0]        busy;

    modport master (
        output write_en, write_dir, write_data, read_dir, issue_en, issue_dir,
        input  read_data, read_ready, busy
    );

    modport slave (
        input  write_en, write_dir, write_data, read_dir, issue_en, issue_dir,
        output read_data, read_ready, busy
    );
endinterface

// File: rtl/reg_bank_mp.sv
// Multi-port register bank: x0 hardwired to zero, same-cycle write bypass,
// per-register pending-write scoreboard, highest write port wins conflicts.
module reg_bank_mp #(
    parameter int DIR_WIDTH  = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 2
) (
    input  logic         clk,
    input  logic         srst,
    reg_bank_mp_if.slave bus
);
    localparam int DEPTH = 1 << DIR_WIDTH;
    localparam logic [DIR_WIDTH-1:0] ZERO_DIR = '0;

    logic [DEPTH-1:0][DATA_WIDTH-1:0]     prf_q, prf_d;
    logic [DEPTH-1:0]                     busy_q, busy_d;

    logic [NUM_WRITE-1:0][DIR_WIDTH-1:0]  wdir;
    logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] wdata;
    logic [NUM_WRITE-1:0]                 wact;
    logic [NUM_READ-1:0][DIR_WIDTH-1:0]   rdir;
    logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rdata;
    logic [NUM_READ-1:0]                  rrdy;
    logic [NUM_READ-1:0]                  rhit;

    assign wdir  = bus.write_dir;
    assign wdata = bus.write_data;
    assign rdir  = bus.read_dir;

    // A write port is only live when enabled and not aimed at x0
    always_comb begin
        wact = '0;
        for (int w = 0; w < NUM_WRITE; w++)
            wact[w] = bus.write_en[w] && (wdir[w] != ZERO_DIR);
    end

    // Next storage state; later ports overwrite earlier ones so the highest index wins
    always_comb begin
        prf_d = prf_q;
        for (int w = 0; w < NUM_WRITE; w++)
            if (wact[w]) prf_d[wdir[w]] = wdata[w];
        prf_d[0] = '0;
    end

    // Next scoreboard: writebacks clear, a new issue sets and overrides the clear
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NUM_WRITE; w++)
            if (wact[w]) busy_d[wdir[w]] = 1'b0;
        if (bus.issue_en) busy_d[bus.issue_dir] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // State registers; reset drops every write and issue of that cycle
    always_ff @(posedge clk) begin
        if (srst) begin
            prf_q  <= '0;
            busy_q <= '0;
        end else begin
            prf_q  <= prf_d;
            busy_q <= busy_d;
        end
    end

    // Read ports: x0 and reset give zero/ready, else bypass from live writes, else storage
    always_comb begin
        rdata = '0;
        rrdy  = '1;
        rhit  = '0;
        for (int r = 0; r < NUM_READ; r++) begin
            if (!srst && (rdir[r] != ZERO_DIR)) begin
                rdata[r] = prf_q[rdir[r]];
                for (int w = 0; w < NUM_WRITE; w++) begin
                    if (wact[w] && (wdir[w] == rdir[r])) begin
                        rdata[r] = wdata[w];
                        rhit[r]  = 1'b1;
                    end
                end
                rrdy[r] = !busy_q[rdir[r]] || rhit[r];
            end
        end
    end

    assign bus.read_data  = rdata;
    assign bus.read_ready = rrdy;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_reg_bank_mp.sv
// Randomised + directed bench for reg_bank_mp against an array-based model.
module tb_reg_bank_mp;
    localparam int DW  = 5;
    localparam int DAT = 32;
    localparam int NR  = 2;
    localparam int NW  = 2;
    localparam int DEP = 32;

    logic clk = 1'b0;
    logic srst;
    int   vecs = 0;
    int   errs = 0;

    logic [DAT-1:0] m_mem [DEP];
    logic [DEP-1:0] m_busy;

    reg_bank_mp_if #(.DIR_WIDTH(DW), .DATA_WIDTH(DAT), .NUM_READ(NR), .NUM_WRITE(NW)) ifc ();

    reg_bank_mp #(.DIR_WIDTH(DW), .DATA_WIDTH(DAT), .NUM_READ(NR), .NUM_WRITE(NW)) dut (
        .clk  (clk),
        .srst (srst),
        .bus  (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DAT-1:0] act, input logic [DAT-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd_dir(input int r);
        return ifc.read_dir[r*DW +: DW];
    endfunction
    function automatic logic [DAT-1:0] rd_data(input int r);
        return ifc.read_data[r*DAT +: DAT];
    endfunction

    task automatic set_w(input int w, input logic en, input logic [DW-1:0] d, input logic [DAT-1:0] v);
        ifc.write_en[w]             = en;
        ifc.write_dir[w*DW +: DW]   = d;
        ifc.write_data[w*DAT +: DAT] = v;
    endtask
    task automatic set_r(input int r, input logic [DW-1:0] d);
        ifc.read_dir[r*DW +: DW] = d;
    endtask
    task automatic idle();
        srst = 1'b0;
        ifc.write_en = '0; ifc.write_dir = '0; ifc.write_data = '0;
        ifc.read_dir = '0; ifc.issue_en = 1'b0; ifc.issue_dir = '0;
    endtask

    // Expected outputs from the current inputs and model state
    task automatic compare_model();
        for (int r = 0; r < NR; r++) begin
            int a = int'(rd_dir(r));
            logic [DAT-1:0] ed;
            logic hit;
            hit = 1'b0;
            ed  = '0;
            if (!srst && a != 0) begin
                ed = m_mem[a];
                for (int w = 0; w < NW; w++)
                    if (ifc.write_en[w] && int'(ifc.write_dir[w*DW +: DW]) == a) begin
                        ed  = ifc.write_data[w*DAT +: DAT];
                        hit = 1'b1;
                    end
            end
            chk($sformatf("model_rdata[%0d]", r), rd_data(r), ed);
            chk($sformatf("model_rready[%0d]", r), {31'b0, ifc.read_ready[r]},
                {31'b0, (srst || a == 0 || !m_busy[a] || hit)});
        end
        chk("model_busy", ifc.busy, m_busy);
    endtask

    // Advance the model across one rising edge
    task automatic model_edge();
        if (srst) begin
            for (int i = 0; i < DEP; i++) m_mem[i] = '0;
            m_busy = '0;
        end else begin
            for (int w = 0; w < NW; w++) begin
                int a = int'(ifc.write_dir[w*DW +: DW]);
                if (ifc.write_en[w] && a != 0) begin
                    m_mem[a]  = ifc.write_data[w*DAT +: DAT];
                    m_busy[a] = 1'b0;
                end
            end
            if (ifc.issue_en && ifc.issue_dir != '0) m_busy[ifc.issue_dir] = 1'b1;
        end
    endtask

    task automatic settle();
        #2;
        compare_model();
    endtask
    task automatic edge_step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask
    task automatic cyc();
        settle();
        edge_step();
    endtask

    initial begin
        m_busy = '0;
        for (int i = 0; i < DEP; i++) m_mem[i] = '0;
        idle();
        srst = 1'b1;
        @(negedge clk);
        edge_step();
        settle();
        chk("rst_ready", {30'b0, ifc.read_ready}, 32'h3);
        chk("rst_rdata0", rd_data(0), 32'h0);
        edge_step();
        srst = 1'b0;

        // Reset contents across all addresses
        for (int a = 0; a < DEP; a++) begin
            set_r(0, DW'(a)); set_r(1, DW'(DEP-1-a));
            settle();
            chk("post_rst_rd0", rd_data(0), 32'h0);
            chk("post_rst_rd1", rd_data(1), 32'h0);
            chk("post_rst_rdy", {30'b0, ifc.read_ready}, 32'h3);
            chk("post_rst_busy", ifc.busy, 32'h0);
            edge_step();
        end

        // Bypass then storage for x5
        idle(); set_w(0, 1, 5, 32'hDEADBEEF); set_r(1, 5);
        settle(); chk("bypass_x5", rd_data(1), 32'hDEADBEEF); edge_step();
        idle(); set_r(0, 5); set_r(1, 5);
        settle(); chk("stored_x5", rd_data(0), 32'hDEADBEEF); edge_step();
        idle(); set_w(0, 1, 0, 32'h1234); set_r(0, 0);
        settle(); chk("x0_bypass", rd_data(0), 32'h0); edge_step();
        idle(); set_r(0, 0);
        settle(); chk("x0_stored", rd_data(0), 32'h0); edge_step();

        // Write conflict on x7
        idle(); set_w(0, 1, 7, 32'h11); set_w(1, 1, 7, 32'h22); set_r(0, 7);
        settle(); chk("conflict_bypass", rd_data(0), 32'h22); edge_step();
        idle(); set_r(1, 7);
        settle(); chk("conflict_stored", rd_data(1), 32'h22); edge_step();

        // Scoreboard on x3
        idle(); ifc.issue_en = 1; ifc.issue_dir = 3; cyc();
        idle(); set_r(0, 3);
        settle();
        chk("x3_not_ready", {31'b0, ifc.read_ready[0]}, 32'h0);
        chk("x3_busy", {31'b0, ifc.busy[3]}, 32'h1);
        edge_step();
        idle(); set_r(0, 3); set_w(1, 1, 3, 32'h55);
        settle();
        chk("x3_wb_ready", {31'b0, ifc.read_ready[0]}, 32'h1);
        chk("x3_wb_data", rd_data(0), 32'h55);
        edge_step();
        idle(); settle(); chk("x3_cleared", {31'b0, ifc.busy[3]}, 32'h0); edge_step();

        // Issue beats writeback on x9
        idle(); ifc.issue_en = 1; ifc.issue_dir = 9; set_w(0, 1, 9, 32'hAA); cyc();
        idle(); set_r(1, 9);
        settle();
        chk("x9_busy", {31'b0, ifc.busy[9]}, 32'h1);
        chk("x9_data", rd_data(1), 32'hAA);
        edge_step();

        // Reset mid-operation on x4
        idle(); set_w(0, 1, 4, 32'h77); ifc.issue_en = 1; ifc.issue_dir = 4; cyc();
        idle(); srst = 1; set_w(1, 1, 4, 32'h99); set_r(0, 4);
        settle();
        chk("rst_x4_data", rd_data(0), 32'h0);
        chk("rst_x4_ready", {31'b0, ifc.read_ready[0]}, 32'h1);
        edge_step();
        idle(); set_r(0, 4);
        settle();
        chk("after_rst_x4", rd_data(0), 32'h0);
        chk("after_rst_busy", ifc.busy, 32'h0);
        edge_step();

        // Random traffic; narrow addresses raise conflict and hazard rates
        for (int n = 0; n < 3000; n++) begin
            int span = ($urandom_range(0, 1) == 1) ? 7 : DEP-1;
            srst = ($urandom_range(0, 59) == 0);
            for (int w = 0; w < NW; w++)
                set_w(w, ($urandom_range(0, 2) == 0), DW'($urandom_range(0, span)), $urandom);
            for (int r = 0; r < NR; r++) set_r(r, DW'($urandom_range(0, span)));
            ifc.issue_en  = ($urandom_range(0, 2) == 0);
            ifc.issue_dir = DW'($urandom_range(0, span));
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
